// File: rtl/imem_uart_loader_if.sv
// Byte-stream input and instruction-memory write port of the UART boot loader.
// master = loader side, slave = UART receiver / instruction memory side.
interface imem_uart_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_uart_loader.sv
// Boot loader: holds the CPU, packs UART bytes into 32-bit instruction-memory writes, then restarts it.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
//
//   state  | meaning
//   IDLE   | no session yet, CPU runs
//   LEN_LO | waiting for word-count low byte
//   LEN_HI | waiting for word-count high byte, length is checked here
//   DATA   | packing bytes into words, writing memory
//   CHK    | waiting for checksum byte (checksum build only)
//   DONE   | image loaded, CPU released
//   ERROR  | session aborted, CPU kept on hold
module imem_uart_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_req,
  imem_uart_loader_if.master    bus,
  output logic                  cpu_hold,
  output logic                  cpu_restart,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int          TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK    = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                load_req_q;
  logic                start;
  logic [7:0]          len_lo;
  logic [15:0]         len_full;
  logic [ADDR_WIDTH:0] len;
  logic [1:0]          byte_idx;
  logic [23:0]         shift;
  logic [TW-1:0]       tmo_cnt;
  logic                tmo_hit;
  logic                word_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  assign start     = load_req && !load_req_q &&
                     (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign len_full  = {bus.rx_data, len_lo};
  assign tmo_hit   = (tmo_cnt == TW'(1)) && !bus.rx_valid;
  // The write of the final word is visible here; the session ends after this cycle.
  assign word_done = bus.mem_we && (word_count == len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (bus.rx_valid) state_next = S_LEN_HI;
        else if (tmo_hit) state_next = S_ERROR;
      end
      S_LEN_HI: begin
        if (bus.rx_valid) begin
          if (len_full == 16'd0)           state_next = S_DONE;
          else if ({1'b0, len_full} > CAP) state_next = S_ERROR;
          else                             state_next = S_DATA;
        end else if (tmo_hit) begin
          state_next = S_ERROR;
        end
      end
      S_DATA: begin
        if (word_done) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          // A checksum byte arriving in the last write cycle is judged right away.
          if (bus.rx_valid) state_next = (bus.rx_data == csum) ? S_DONE : S_ERROR;
          else              state_next = S_CHK;
`else
          state_next = S_DONE;
`endif
        end else if (tmo_hit) begin
          state_next = S_ERROR;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (bus.rx_valid) state_next = (bus.rx_data == csum) ? S_DONE : S_ERROR;
        else if (tmo_hit) state_next = S_ERROR;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_hold = 1'b0;
    busy     = 1'b0;
    unique case (state)
      S_LEN_LO, S_LEN_HI, S_DATA: begin
        cpu_hold = 1'b1;
        busy     = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        cpu_hold = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_ERROR: cpu_hold = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_req_q    <= 1'b0;
      len_lo        <= 8'd0;
      len           <= '0;
      byte_idx      <= 2'd0;
      shift         <= 24'd0;
      tmo_cnt       <= '0;
      word_count    <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      cpu_restart   <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum          <= 8'd0;
`endif
    end else begin
      load_req_q  <= load_req;
      bus.mem_we  <= 1'b0;
      cpu_restart <= 1'b0;
      if (start) begin
        load_done  <= 1'b0;
        load_err   <= 1'b0;
        word_count <= '0;
        len_lo     <= 8'd0;
        len        <= '0;
        byte_idx   <= 2'd0;
        tmo_cnt    <= TW'(TIMEOUT_CYCLES);
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum       <= 8'd0;
`endif
      end else begin
        // Idle timer: reloads on every byte, counts down to terminal count 1.
        if (busy) begin
          if (bus.rx_valid)         tmo_cnt <= TW'(TIMEOUT_CYCLES);
          else if (tmo_cnt != '0)   tmo_cnt <= tmo_cnt - TW'(1);
        end
        if (bus.rx_valid) begin
          unique case (state)
            S_LEN_LO: begin
              len_lo <= bus.rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum   <= csum ^ bus.rx_data;
`endif
            end
            S_LEN_HI: begin
              len <= len_full[ADDR_WIDTH:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum <= csum ^ bus.rx_data;
`endif
            end
            S_DATA: begin
              if (!word_done) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum <= csum ^ bus.rx_data;
`endif
                byte_idx <= byte_idx + 2'd1;
                unique case (byte_idx)
                  2'd0: shift[7:0]   <= bus.rx_data;
                  2'd1: shift[15:8]  <= bus.rx_data;
                  2'd2: shift[23:16] <= bus.rx_data;
                  default: begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= {{(29 - ADDR_WIDTH){1'b0}}, word_count, 2'b00};
                    bus.mem_wdata <= {bus.rx_data, shift};
                    word_count    <= word_count + 1'b1;
                  end
                endcase
              end
            end
            default: ;
          endcase
        end
      end
      if (state_next == S_DONE && state != S_DONE) begin
        cpu_restart <= 1'b1;
        load_done   <= 1'b1;
      end
      if (state_next == S_ERROR && state != S_ERROR) load_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: frame-level model predicts writes and final status.
// Define IMEM_LOADER_CHECKSUM_EN for both bench and RTL to cover the checksum build.
module tb_imem_uart_loader;
  localparam int AW  = 8;
  localparam int TMO = 16;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          reset;
  logic          load_req;
  logic          cpu_hold, cpu_restart, busy, load_done, load_err;
  logic [AW:0]   word_count;

  imem_uart_loader_if bus();

  imem_uart_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_req   (load_req),
    .bus        (bus.master),
    .cpu_hold   (cpu_hold),
    .cpu_restart(cpu_restart),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  bit          exp_done, exp_err;
  int          exp_wc;
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  int          restart_cnt = 0;
  int          writes_seen = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Frame-level model: what a complete or truncated frame must produce.
  task automatic predict(input bq_t f);
    int n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
`endif
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_done = 0;
    exp_err  = 0;
    exp_wc   = 0;
    if (f.size() < 2) begin exp_err = 1; return; end
    n = int'(f[0]) + 256 * int'(f[1]);
    if (n == 0) begin exp_done = 1; return; end
    if (n > (1 << AW)) begin exp_err = 1; return; end
    for (int w = 0; w < n; w++) begin
      if (f.size() < 6 + 4 * w) begin exp_err = 1; return; end
      exp_addr_q.push_back(32'(4 * w));
      exp_data_q.push_back({f[5 + 4*w], f[4 + 4*w], f[3 + 4*w], f[2 + 4*w]});
      exp_wc++;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (f.size() < 3 + 4 * n) begin exp_err = 1; return; end
    x = 8'd0;
    for (int i = 0; i < 2 + 4 * n; i++) x ^= f[i];
    if (x == f[2 + 4*n]) exp_done = 1;
    else                 exp_err  = 1;
`else
    exp_done = 1;
`endif
  endtask

  function automatic bq_t with_csum(input bq_t f);
    bq_t r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
`endif
    r = f;
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = 8'd0;
    foreach (f[i]) x ^= f[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.mem_we === 1'b1) begin
        writes_seen++;
        cap_addr.push_back(bus.mem_addr);
        cap_data.push_back(bus.mem_wdata);
        chk(busy === 1'b1, "write_outside_data", 32'(busy), 32'd1);
        chk(exp_addr_q.size() != 0, "write_expected", bus.mem_addr, 32'd0);
        if (exp_addr_q.size() != 0) begin
          chk(bus.mem_addr === exp_addr_q[0], "write_addr", bus.mem_addr, exp_addr_q[0]);
          chk(bus.mem_wdata === exp_data_q[0], "write_data", bus.mem_wdata, exp_data_q[0]);
          void'(exp_addr_q.pop_front());
          void'(exp_data_q.pop_front());
        end
      end
      if (cpu_restart === 1'b1) begin
        restart_cnt++;
        chk(cpu_hold === 1'b0 && load_done === 1'b1, "restart_status",
            {30'd0, cpu_hold, load_done}, 32'd1);
      end
      if (busy === 1'b1) begin
        chk(cpu_hold === 1'b1, "hold_while_busy", 32'(cpu_hold), 32'd1);
        chk(word_count === (AW+1)'(writes_seen), "word_count_track", 32'(word_count), 32'(writes_seen));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bq_t f, input int gap);
    foreach (f[i]) begin
      send_byte(f[i]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic start_session();
    restart_cnt = 0;
    writes_seen = 0;
    cap_addr.delete();
    cap_data.delete();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk(cpu_hold === 1'b1, "start_hold", 32'(cpu_hold), 32'd1);
    chk(busy === 1'b1, "start_busy", 32'(busy), 32'd1);
    chk(load_done === 1'b0 && load_err === 1'b0, "start_status_clear",
        {30'd0, load_done, load_err}, 32'd0);
    chk(word_count === '0, "start_word_count", 32'(word_count), 32'd0);
  endtask

  task automatic finish_session(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(busy === 1'b0, {tag, "_end_reached"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk(load_done === exp_done, {tag, "_load_done"}, 32'(load_done), 32'(exp_done));
    chk(load_err === exp_err, {tag, "_load_err"}, 32'(load_err), 32'(exp_err));
    chk(word_count === (AW+1)'(exp_wc), {tag, "_word_count"}, 32'(word_count), 32'(exp_wc));
    chk(cpu_hold === exp_err, {tag, "_cpu_hold"}, 32'(cpu_hold), 32'(exp_err));
    chk(restart_cnt == (exp_done ? 1 : 0), {tag, "_restart_pulses"}, 32'(restart_cnt), 32'(exp_done));
    chk(exp_addr_q.size() == 0, {tag, "_writes_missing"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f;
    reset        = 1'b1;
    load_req     = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    repeat (3) @(negedge clk);
    chk({cpu_hold, cpu_restart, busy, load_done, load_err, bus.mem_we} === 6'd0,
        "reset_flags", {26'd0, cpu_hold, cpu_restart, busy, load_done, load_err, bus.mem_we}, 32'd0);
    chk(bus.mem_addr === 32'd0 && bus.mem_wdata === 32'd0 && word_count === '0,
        "reset_bus", bus.mem_addr | bus.mem_wdata | 32'(word_count), 32'd0);
    reset = 1'b0;

    // Idle without load_req: nothing moves.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk({cpu_hold, cpu_restart, busy, load_done, load_err, bus.mem_we} === 6'd0 && word_count === '0,
          "idle_quiet", {26'd0, cpu_hold, cpu_restart, busy, load_done, load_err, bus.mem_we}, 32'd0);
    end

    // Two-word program.
    f = with_csum({8'h02, 8'h00, 8'h21, 8'h00, 8'h08, 8'h00, 8'h08, 8'h00, 8'hE0, 8'h03});
    predict(f);
    start_session();
    send_frame(f, 1);
    finish_session("two_words");
    chk(cap_addr.size() == 2, "two_words_count", 32'(cap_addr.size()), 32'd2);
    if (cap_addr.size() == 2) begin
      chk(cap_addr[0] === 32'h0 && cap_data[0] === 32'h00080021, "two_words_w0", cap_data[0], 32'h00080021);
      chk(cap_addr[1] === 32'h4 && cap_data[1] === 32'h03E00008, "two_words_w1", cap_data[1], 32'h03E00008);
    end

    // N = 257 exceeds capacity.
    f = {8'h01, 8'h01};
    predict(f);
    start_session();
    send_frame(f, 1);
    finish_session("too_long");

    // Timeout after 16 idle cycles, starting from ERROR.
    f = {8'h02, 8'h00, 8'hAA};
    predict(f);
    start_session();
    send_frame(f, 0);
    repeat (TMO - 1) @(negedge clk);
    chk(busy === 1'b1 && load_err === 1'b0, "timeout_not_early", {30'd0, busy, load_err}, 32'd2);
    @(negedge clk);
    chk(busy === 1'b0 && load_err === 1'b1, "timeout_expired", {30'd0, busy, load_err}, 32'd1);
    finish_session("timeout");

    // Empty image.
    f = {8'h00, 8'h00};
    predict(f);
    start_session();
    send_frame(f, 2);
    finish_session("empty");

    // Back-to-back bytes, with a load_req edge mid-session that must be ignored.
    f = with_csum({8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40,
                   8'hA5, 8'h5A, 8'hC3, 8'h3C});
    predict(f);
    start_session();
    foreach (f[i]) begin
      if (i == 7)  load_req = 1'b1;
      if (i == 10) load_req = 1'b0;
      send_byte(f[i]);
    end
    finish_session("back_to_back");
    chk(cap_data.size() == 3, "b2b_count", 32'(cap_data.size()), 32'd3);
    if (cap_data.size() == 3)
      chk(cap_data[2] === 32'h3CC35AA5 && cap_addr[2] === 32'h8, "b2b_w2", cap_data[2], 32'h3CC35AA5);

    // A byte landing on the timer's last cycle wins.
    f = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    predict(f);
    start_session();
    send_byte(f[0]);
    send_byte(f[1]);
    send_byte(f[2]);
    repeat (TMO - 1) @(negedge clk);
    for (int i = 3; i < 7; i++) send_byte(f[i]);
    finish_session("byte_wins");
    chk(cap_data.size() == 1, "byte_wins_count", 32'(cap_data.size()), 32'd1);
    if (cap_data.size() == 1)
      chk(cap_data[0] === 32'h44332211, "byte_wins_word", cap_data[0], 32'h44332211);

    // Asynchronous reset mid-session, then a clean reload.
    exp_addr_q.delete();
    exp_data_q.delete();
    start_session();
    send_frame({8'h02, 8'h00, 8'h55}, 0);
    #2 reset = 1'b1;
    #1;
    chk({cpu_hold, busy, load_err, load_done, bus.mem_we} === 5'd0 && word_count === '0,
        "async_reset", {27'd0, cpu_hold, busy, load_err, load_done, bus.mem_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    f = with_csum({8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
    predict(f);
    start_session();
    send_frame(f, 1);
    finish_session("after_reset");
    if (cap_data.size() == 1)
      chk(cap_data[0] === 32'hEFBEADDE, "after_reset_word", cap_data[0], 32'hEFBEADDE);

`ifdef IMEM_LOADER_CHECKSUM_EN
    f = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h46};
    predict(f);
    start_session();
    send_frame(f, 1);
    finish_session("bad_checksum");
    chk(cap_data.size() == 1, "bad_checksum_write", 32'(cap_data.size()), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Boot-time controller for the writable instruction memory (256 words, indexed by Address[9:2]) of the pipelined CPU.
- While loading, it holds the CPU, takes a byte stream from the UART receiver, packs bytes into 32-bit words and issues word writes to instruction memory.
- On completion it releases the CPU with a one-cycle restart pulse, so fetch begins at PC 0 with the new program.
- Sits between the UART RX and the instruction memory write port, next to the CPU reset logic.

Parameters:
ADDR_WIDTH, 8, word-address width; capacity = 2^ADDR_WIDTH words
TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted bytes before abort (>=2)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
load_req  in  1  level request to enter load mode; a rising edge starts a session
rx_valid  in  1  one-cycle strobe, rx_data valid this cycle
rx_data  in  8  received byte
cpu_hold  out  1  stall/hold CPU fetch while high
cpu_restart  out  1  one-cycle pulse: CPU must reset its PC to 0
mem_we  out  1  instruction-memory write enable, one-cycle pulse per word
mem_addr  out  32  byte address of write, word-aligned (bits [1:0]=0)
mem_wdata  out  32  write data
busy  out  1  high in LEN_LO, LEN_HI, DATA (and CHK)
load_done  out  1  sticky: last session completed successfully
load_err  out  1  sticky: last session aborted
word_count  out  ADDR_WIDTH+1  words written in current/last session

Behaviour:
- Reset values: cpu_hold=0, cpu_restart=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, load_done=0, load_err=0, word_count=0, state=IDLE; all internal counters 0.
- load_req edge detection uses a registered previous value (reset 0). A rising edge in IDLE, DONE or ERROR starts a session:
  - clears load_done, load_err and word_count;
  - asserts cpu_hold in the next cycle;
  - enters LEN_LO.
- A rising edge while busy is ignored.
- Frame format: LEN_LO, LEN_HI (word count N, little-endian 16 bit), then N words of 4 bytes each, least significant byte first. Byte k of a word lands in bits [8k+7:8k].
- States:
  - IDLE: cpu_hold=0.
  - LEN_LO: capture N[7:0] on rx_valid.
  - LEN_HI: capture N[15:8] on rx_valid.
    - If N=0, go to DONE.
    - If N > 2^ADDR_WIDTH, go to ERROR.
    - Otherwise go to DATA.
  - DATA: shift in bytes. On the 4th byte of a word, the next cycle has:
    - mem_we=1;
    - mem_addr = word_count*4;
    - mem_wdata = assembled word;
    - word_count incremented in the same cycle.
    After the write for word N-1, go to DONE (or CHK when the optional feature is enabled).
  - DONE: cpu_hold=0, load_done=1. cpu_restart=1 for exactly the first cycle in DONE.
  - ERROR: load_err=1, cpu_hold stays 1 (the CPU never runs a partial image). Exits only on reset or a new load_req rising edge.
- mem_we is never high outside DATA. Addresses never wrap: the length check guarantees mem_addr < 4*2^ADDR_WIDTH.
- Timeout:
  - The idle counter clears on every accepted byte and on session start.
  - In LEN_LO, LEN_HI, DATA and CHK, the counter reaching TIMEOUT_CYCLES goes to ERROR.
  - If the timeout and rx_valid occur in the same cycle, the byte wins and the counter clears.
- rx_valid in IDLE, DONE or ERROR is ignored. A byte arriving in the mem_we cycle is accepted as byte 0 of the next word; no byte is dropped at back-to-back rate.
- load_req falling while busy has no effect; the session completes or times out.
- Asynchronous reset mid-session returns all outputs to reset values immediately, including cpu_hold=0. The memory contents already written are not undone.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN
- With the macro defined:
  - After the last word, state CHK expects one byte equal to the XOR of all preceding frame bytes, including the length bytes.
  - A match goes to DONE; a mismatch goes to ERROR.
  - The running XOR resets at session start.
- Without the macro: no CHK state; after the last word, go directly to DONE; no checksum byte is expected.

Test Plan:
- Reset, then no load_req for 100 cycles -> cpu_hold=0, mem_we never 1, all status outputs 0.
- load_req rise, bytes 02 00, 21 00 08 00, 08 00 E0 03 ->
  - mem_we pulses: addr 0x0 data 0x00080021, then addr 0x4 data 0x03E00008;
  - word_count=2, load_done=1;
  - a single cpu_restart pulse, cpu_hold falls in the DONE entry cycle.
- Length bytes 01 01 (N=257, ADDR_WIDTH=8) -> ERROR, load_err=1, cpu_hold stays 1, no mem_we.
- TIMEOUT_CYCLES=16, send 02 00 AA then idle for 16 cycles -> ERROR, load_err=1, no write issued; a new load_req edge clears load_err and restarts.
- Length 00 00 -> DONE immediately after LEN_HI, cpu_restart pulse, word_count=0, no mem_we.
- Checksum macro on, frame 01 00 11 22 33 44 checksum 45 -> DONE with the word written; the same frame with checksum 46 -> ERROR after the word write, load_err=1.
